// File: rtl/codec_cfg_sequencer.sv
// Audio codec configuration sequencer: writes the fixed register table through the
// I2C master with retry/timeout, then gates I2S streaming and services volume updates.
module codec_cfg_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_ack_ok,
  output logic        i2c_start,
  output logic [15:0] i2c_word,
  input  logic        vol_req,
  input  logic [6:0]  vol_value,
  output logic        vol_ack,
  output logic        stream_en,
  output logic        config_done,
  output logic        config_error,
  output logic [3:0]  cfg_index
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_FREE = 4'd1;
  localparam logic [3:0] S_ISSUE     = 4'd2;
  localparam logic [3:0] S_WAIT_DONE = 4'd3;
  localparam logic [3:0] S_NEXT      = 4'd4;
  localparam logic [3:0] S_RUN       = 4'd5;
  localparam logic [3:0] S_VOL_L     = 4'd6;
  localparam logic [3:0] S_VOL_R     = 4'd7;
  localparam logic [3:0] S_ERROR     = 4'd8;

  localparam logic [1:0] M_CFG   = 2'd0;
  localparam logic [1:0] M_LEFT  = 2'd1;
  localparam logic [1:0] M_RIGHT = 2'd2;

  logic [3:0]    state_reg, state_next;
  logic [3:0]    index_reg, index_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [1:0]    mode_reg, mode_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          configured_reg, configured_next;
  logic          error_reg, error_next;
  logic          go_reg;
  logic          pending_reg;
  logic [6:0]    pend_val_reg;
  logic [6:0]    vol_work_reg;
  logic          start_reg;
  logic [15:0]   word_reg;
  logic          ack_reg;

  logic          ack_pulse;
  logic          capture;
  logic          fail;
  logic [15:0]   table_word;
  logic [15:0]   word_sel;

  always_comb begin
    case (index_reg)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0017;
      4'd2:    table_word = 16'h0217;
      4'd3:    table_word = 16'h047F;
      4'd4:    table_word = 16'h067F;
      4'd5:    table_word = 16'h0812;
      4'd6:    table_word = 16'h0A06;
      4'd7:    table_word = 16'h0C02;
      4'd8:    table_word = 16'h0E23;
      4'd9:    table_word = 16'h1001;
      default: table_word = 16'h1201;
    endcase
  end

  always_comb begin
    case (mode_reg)
      M_LEFT:  word_sel = {7'h02, 2'b01, vol_work_reg};
      M_RIGHT: word_sel = {7'h03, 2'b01, vol_work_reg};
      default: word_sel = table_word;
    endcase
  end

  // A done pulse in the expiry cycle wins over the timeout.
  assign fail = i2c_done ? !i2c_ack_ok : (timer_reg == '0);

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    retry_next      = retry_reg;
    mode_next       = mode_reg;
    timer_next      = timer_reg;
    configured_next = configured_reg;
    error_next      = error_reg;
    ack_pulse       = 1'b0;
    capture         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (go_reg) begin
          state_next = S_WAIT_FREE;
          index_next = '0;
          retry_next = '0;
          mode_next  = M_CFG;
        end
      end
      S_WAIT_FREE: begin
        if (!i2c_busy) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        timer_next = TIMER_LOAD;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (timer_reg != '0) timer_next = timer_reg - 1'b1;
        if (i2c_done && i2c_ack_ok) begin
          case (mode_reg)
            M_LEFT:  state_next = S_VOL_R;
            M_RIGHT: begin
              state_next = S_RUN;
              ack_pulse  = 1'b1;
            end
            default: state_next = S_NEXT;
          endcase
        end else if (fail) begin
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 1'b1;
            state_next = S_WAIT_FREE;
          end else begin
            state_next      = S_ERROR;
            error_next      = 1'b1;
            configured_next = 1'b0;
          end
        end
      end
      S_NEXT: begin
        retry_next = '0;
        if (index_reg == 4'd10) begin
          state_next      = S_RUN;
          configured_next = 1'b1;
        end else begin
          index_next = index_reg + 1'b1;
          state_next = S_WAIT_FREE;
        end
      end
      S_RUN: begin
        if (pending_reg) begin
          state_next = S_VOL_L;
          capture    = 1'b1;
        end
      end
      S_VOL_L: begin
        mode_next  = M_LEFT;
        retry_next = '0;
        state_next = S_WAIT_FREE;
      end
      S_VOL_R: begin
        mode_next  = M_RIGHT;
        retry_next = '0;
        state_next = S_WAIT_FREE;
      end
      default: state_next = S_ERROR;
    endcase

    // Restart waits for the bus to go idle, so any in-flight transfer drains first.
    if (start && state_reg != S_IDLE) begin
      state_next      = S_WAIT_FREE;
      index_next      = '0;
      retry_next      = '0;
      mode_next       = M_CFG;
      configured_next = 1'b0;
      error_next      = 1'b0;
      ack_pulse       = 1'b0;
      capture         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      index_reg      <= '0;
      retry_reg      <= '0;
      mode_reg       <= M_CFG;
      timer_reg      <= '0;
      configured_reg <= 1'b0;
      error_reg      <= 1'b0;
      go_reg         <= AUTO_START;
      pending_reg    <= 1'b0;
      pend_val_reg   <= '0;
      vol_work_reg   <= '0;
      start_reg      <= 1'b0;
      word_reg       <= 16'h1E00;
      ack_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      retry_reg      <= retry_next;
      mode_reg       <= mode_next;
      timer_reg      <= timer_next;
      configured_reg <= configured_next;
      error_reg      <= error_next;
      go_reg         <= start && (state_reg == S_IDLE) && !go_reg;
      start_reg      <= (state_next == S_ISSUE);
      ack_reg        <= ack_pulse;
      if (state_next == S_ISSUE) word_reg <= word_sel;

      // A request arriving as VOL_L is entered stays queued for the next pair.
      if (start) begin
        pending_reg <= 1'b0;
      end else if (capture) begin
        vol_work_reg <= pend_val_reg;
        pending_reg  <= vol_req;
        if (vol_req) pend_val_reg <= vol_value;
      end else if (vol_req) begin
        pending_reg  <= 1'b1;
        pend_val_reg <= vol_value;
      end
    end
  end

  assign i2c_start    = start_reg;
  assign i2c_word     = word_reg;
  assign vol_ack      = ack_reg;
  assign stream_en    = configured_reg;
  assign config_done  = configured_reg;
  assign config_error = error_reg;
  assign cfg_index    = index_reg;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: acts as the I2C master and checks words,
// cycle-exact latencies, retries, timeout, restart and volume arbitration.
module tb_codec_cfg_sequencer;

  localparam int T = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_ok = 1'b0;
  logic        i2c_start;
  logic [15:0] i2c_word;
  logic        vol_req = 1'b0;
  logic [6:0]  vol_value = '0;
  logic        vol_ack;
  logic        stream_en;
  logic        config_done;
  logic        config_error;
  logic [3:0]  cfg_index;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h047F, 16'h067F, 16'h0812,
                            16'h0A06, 16'h0C02, 16'h0E23, 16'h1001, 16'h1201};

  codec_cfg_sequencer #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES(3),
    .AUTO_START(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .i2c_busy(i2c_busy),
    .i2c_done(i2c_done),
    .i2c_ack_ok(i2c_ack_ok),
    .i2c_start(i2c_start),
    .i2c_word(i2c_word),
    .vol_req(vol_req),
    .vol_value(vol_value),
    .vol_ack(vol_ack),
    .stream_en(stream_en),
    .config_done(config_done),
    .config_error(config_error),
    .cfg_index(cfg_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag, input logic [15:0] exp, output int ts);
    int n = 0;
    while (!i2c_start && n < 400) begin
      step();
      n++;
    end
    check({tag, " issued"}, 32'(i2c_start), 32'd1);
    check({tag, " word"}, 32'(i2c_word), 32'(exp));
    ts = cyc;
    $display("issue %s word=%h cycle=%0d", tag, i2c_word, cyc);
  endtask

  task automatic xact(input int delay, input bit ack, input logic [15:0] exp, input string tag,
                      output int ts, output int td);
    wait_issue(tag, exp, ts);
    i2c_busy = 1'b1;
    repeat (delay) step();
    check({tag, " hold"}, 32'(i2c_word), 32'(exp));
    i2c_done   = 1'b1;
    i2c_ack_ok = ack;
    i2c_busy   = 1'b0;
    td = cyc;
    step();
    i2c_done   = 1'b0;
    i2c_ack_ok = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    int cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (i2c_start) cnt++;
    end
    check({tag, " no issue"}, 32'(cnt), 32'd0);
  endtask

  task automatic vol_pulse(input logic [6:0] v);
    vol_req   = 1'b1;
    vol_value = v;
    step();
    vol_req   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int ts, td, prev;

    // Reset state and auto-start latency
    repeat (3) step();
    check("rst i2c_start", 32'(i2c_start), 32'd0);
    check("rst i2c_word", 32'(i2c_word), 32'h1E00);
    check("rst vol_ack", 32'(vol_ack), 32'd0);
    check("rst stream_en", 32'(stream_en), 32'd0);
    check("rst config_done", 32'(config_done), 32'd0);
    check("rst config_error", 32'(config_error), 32'd0);
    check("rst cfg_index", 32'(cfg_index), 32'd0);
    reset = 1'b0;
    step();
    check("auto early", 32'(i2c_start), 32'd0);
    step();
    check("auto latency", 32'(i2c_start), 32'd1);

    // Full table, each word answered after 100 cycles
    prev = 0;
    for (int i = 0; i < 11; i++) begin
      xact(100, 1'b1, tbl[i], $sformatf("cfgA[%0d]", i), ts, td);
      if (i > 0) check($sformatf("cfgA[%0d] gap", i), 32'(ts - prev), 32'd3);
      prev = td;
    end
    check("cfgA stream m+1", 32'(stream_en), 32'd0);
    step();
    check("cfgA stream m+2", 32'(stream_en), 32'd1);
    check("cfgA done m+2", 32'(config_done), 32'd1);
    check("cfgA index", 32'(cfg_index), 32'd10);
    check("cfgA error", 32'(config_error), 32'd0);

    // Volume pair in RUN, with a second request queued during the pair
    vol_pulse(7'h50);
    xact(20, 1'b1, 16'h04D0, "volL 50", ts, td);
    check("vol stream mid", 32'(stream_en), 32'd1);
    vol_pulse(7'h33);
    xact(20, 1'b1, 16'h06D0, "volR 50", ts, td);
    check("vol ack 50", 32'(vol_ack), 32'd1);
    check("vol stream end", 32'(stream_en), 32'd1);
    step();
    check("vol ack width", 32'(vol_ack), 32'd0);
    xact(20, 1'b1, 16'h04B3, "volL 33", ts, td);
    xact(20, 1'b1, 16'h06B3, "volR 33", ts, td);
    check("vol ack 33", 32'(vol_ack), 32'd1);
    quiet(40, "vol idle");

    // Restart from RUN; NACK entry 3 twice; two volume requests during configuration
    start_pulse();
    check("restart stream clr", 32'(stream_en), 32'd0);
    check("restart done clr", 32'(config_done), 32'd0);
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        xact(10, 1'b0, tbl[3], "cfgC[3] try0", ts, td);
        xact(10, 1'b0, tbl[3], "cfgC[3] try1", ts, td);
        prev = td;
        xact(10, 1'b1, tbl[3], "cfgC[3] try2", ts, td);
        check("cfgC retry gap", 32'(ts - prev), 32'd2);
        check("cfgC retry index", 32'(cfg_index), 32'd3);
      end else begin
        xact(10, 1'b1, tbl[i], $sformatf("cfgC[%0d]", i), ts, td);
      end
      if (i == 2) vol_pulse(7'h10);
      if (i == 8) vol_pulse(7'h20);
    end
    step();
    check("cfgC done", 32'(config_done), 32'd1);
    xact(10, 1'b1, 16'h04A0, "volL 20", ts, td);
    xact(10, 1'b1, 16'h06A0, "volR 20", ts, td);
    check("vol ack 20", 32'(vol_ack), 32'd1);
    quiet(40, "vol 10 dropped");

    // Restart (with a simultaneous volume request) during entry 6 WAIT_DONE
    start_pulse();
    for (int i = 0; i < 6; i++) xact(10, 1'b1, tbl[i], $sformatf("cfgD[%0d]", i), ts, td);
    wait_issue("cfgD[6]", tbl[6], ts);
    i2c_busy = 1'b1;
    repeat (20) step();
    start     = 1'b1;
    vol_req   = 1'b1;
    vol_value = 7'h7F;
    step();
    start   = 1'b0;
    vol_req = 1'b0;
    check("restart index", 32'(cfg_index), 32'd0);
    quiet(30, "restart bus busy");
    i2c_done   = 1'b1;
    i2c_ack_ok = 1'b1;
    i2c_busy   = 1'b0;
    step();
    i2c_done   = 1'b0;
    i2c_ack_ok = 1'b0;
    for (int i = 0; i < 11; i++) xact(10, 1'b1, tbl[i], $sformatf("cfgD2[%0d]", i), ts, td);
    step();
    check("cfgD done", 32'(config_done), 32'd1);
    quiet(40, "start beats vol");

    // Entry 5 never answered: four attempts T+2 apart, then ERROR
    start_pulse();
    for (int i = 0; i < 5; i++) xact(10, 1'b1, tbl[i], $sformatf("cfgE[%0d]", i), ts, td);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      wait_issue($sformatf("cfgE[5] try%0d", k), tbl[5], ts);
      check($sformatf("cfgE try%0d index", k), 32'(cfg_index), 32'd5);
      if (k > 0) check($sformatf("cfgE try%0d gap", k), 32'(ts - prev), 32'(T + 2));
      prev = ts;
    end
    repeat (T) step();
    check("timeout err early", 32'(config_error), 32'd0);
    step();
    check("timeout err", 32'(config_error), 32'd1);
    check("timeout stream", 32'(stream_en), 32'd0);
    check("timeout done", 32'(config_done), 32'd0);
    vol_pulse(7'h11);
    quiet(150, "error hold");
    check("error sticky", 32'(config_error), 32'd1);

    // start leaves ERROR
    start_pulse();
    check("error clr", 32'(config_error), 32'd0);
    xact(10, 1'b1, tbl[0], "cfgF[0]", ts, td);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
